// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Shares one ALU control decoder + ALU pair between two requesters. The
// winner of arbitration is registered onto the ALU-facing outputs. Its
// result is captured one cycle later and is returned on a tagged
// valid/ready response channel. Only one operation can be in flight at a time.
//
// Ports:
//   clk_i, rst_i                       clock (rising edge), async active-high reset
//   Req{0,1}Valid_i / Req{0,1}Ready_o  request handshake (ready is combinational)
//   Req{0,1}ALUOp_i/Funct3_i/Funct7_i  request control fields
//   Req{0,1}A_i / Req{0,1}B_i          request operands
//   ALUOp_o, Funct3_o, Funct7_o        registered controls to the ALU decoder
//   OperandA_o, OperandB_o             registered operands to the ALU
//   ALUResult_i                        combinational ALU result
//   RspValid_o / RspReady_i            response handshake
//   RspId_o, RspData_o                 response requester index and data
//   Busy_o                             high while an operation is in flight
//
// Build option:
//   ARB_FIXED_PRIO_EN  when defined, requester 0 always wins a contention.
//                      When undefined, contentions are resolved round-robin.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; ready is offered to the granted requester
// EXEC  | ALU inputs are stable; the result is captured at the end of this cycle
// RESP  | the response is held until the consumer takes it

module alu_share_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            Req0Valid_i,
  output logic            Req0Ready_o,
  input  logic [1:0]      Req0ALUOp_i,
  input  logic [2:0]      Req0Funct3_i,
  input  logic [6:0]      Req0Funct7_i,
  input  logic [XLEN-1:0] Req0A_i,
  input  logic [XLEN-1:0] Req0B_i,
  input  logic            Req1Valid_i,
  output logic            Req1Ready_o,
  input  logic [1:0]      Req1ALUOp_i,
  input  logic [2:0]      Req1Funct3_i,
  input  logic [6:0]      Req1Funct7_i,
  input  logic [XLEN-1:0] Req1A_i,
  input  logic [XLEN-1:0] Req1B_i,
  output logic [1:0]      ALUOp_o,
  output logic [2:0]      Funct3_o,
  output logic [6:0]      Funct7_o,
  output logic [XLEN-1:0] OperandA_o,
  output logic [XLEN-1:0] OperandB_o,
  input  logic [XLEN-1:0] ALUResult_i,
  output logic            RspValid_o,
  input  logic            RspReady_i,
  output logic            RspId_o,
  output logic [XLEN-1:0] RspData_o,
  output logic            Busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   grant;
  logic   any_valid;
  logic   accept;

  assign any_valid = Req0Valid_i | Req1Valid_i;
  assign accept    = (state_q == IDLE) && any_valid;

`ifdef ARB_FIXED_PRIO_EN
  // Requester 0 wins whenever it is valid.
  assign grant = ~Req0Valid_i;
`else
  // Reset value 1 so that requester 0 wins the first contention.
  logic last_grant;

  always_comb begin
    if (Req0Valid_i && Req1Valid_i) begin
      grant = ~last_grant;
    end else begin
      grant = ~Req0Valid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

  assign Req0Ready_o = (state_q == IDLE) && Req0Valid_i && (grant == 1'b0);
  assign Req1Ready_o = (state_q == IDLE) && Req1Valid_i && (grant == 1'b1);
  assign Busy_o      = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (RspReady_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The ALU-facing registers keep the last request after the return to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ALUOp_o    <= '0;
      Funct3_o   <= '0;
      Funct7_o   <= '0;
      OperandA_o <= '0;
      OperandB_o <= '0;
      RspId_o    <= 1'b0;
    end else if (accept) begin
      ALUOp_o    <= grant ? Req1ALUOp_i  : Req0ALUOp_i;
      Funct3_o   <= grant ? Req1Funct3_i : Req0Funct3_i;
      Funct7_o   <= grant ? Req1Funct7_i : Req0Funct7_i;
      OperandA_o <= grant ? Req1A_i      : Req0A_i;
      OperandB_o <= grant ? Req1B_i      : Req0B_i;
      RspId_o    <= grant;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      RspValid_o <= 1'b0;
      RspData_o  <= '0;
    end else begin
      if (state_q == EXEC) begin
        RspData_o  <= ALUResult_i;
        RspValid_o <= 1'b1;
      end else if ((state_q == RESP) && RspReady_i) begin
        RspValid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam int XLEN = 32;

  typedef struct {
    logic [1:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } req_t;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            Req0Valid_i = 1'b0, Req1Valid_i = 1'b0;
  logic            Req0Ready_o, Req1Ready_o;
  logic [1:0]      Req0ALUOp_i = '0, Req1ALUOp_i = '0;
  logic [2:0]      Req0Funct3_i = '0, Req1Funct3_i = '0;
  logic [6:0]      Req0Funct7_i = '0, Req1Funct7_i = '0;
  logic [XLEN-1:0] Req0A_i = '0, Req0B_i = '0, Req1A_i = '0, Req1B_i = '0;
  logic [1:0]      ALUOp_o;
  logic [2:0]      Funct3_o;
  logic [6:0]      Funct7_o;
  logic [XLEN-1:0] OperandA_o, OperandB_o, ALUResult_i, RspData_o;
  logic            RspValid_o, RspId_o, Busy_o;
  logic            RspReady_i = 1'b0;

  int total = 0;
  int bad   = 0;
  int last_ref = 1;   // index of the requester served most recently

  always #5 clk_i = ~clk_i;

  // Stand-in ALU: plain arithmetic on the control word.
  function automatic logic [XLEN-1:0] alu_ref(input logic [1:0] op, input logic [2:0] f3,
                                              input logic [6:0] f7, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a ^ b;
      2'b10:   return a - b;
      default: return (a & b) ^ {{(XLEN-10){1'b0}}, f7, f3};
    endcase
  endfunction

  assign ALUResult_i = alu_ref(ALUOp_o, Funct3_o, Funct7_o, OperandA_o, OperandB_o);

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .Req0Valid_i(Req0Valid_i), .Req0Ready_o(Req0Ready_o), .Req0ALUOp_i(Req0ALUOp_i),
    .Req0Funct3_i(Req0Funct3_i), .Req0Funct7_i(Req0Funct7_i), .Req0A_i(Req0A_i), .Req0B_i(Req0B_i),
    .Req1Valid_i(Req1Valid_i), .Req1Ready_o(Req1Ready_o), .Req1ALUOp_i(Req1ALUOp_i),
    .Req1Funct3_i(Req1Funct3_i), .Req1Funct7_i(Req1Funct7_i), .Req1A_i(Req1A_i), .Req1B_i(Req1B_i),
    .ALUOp_o(ALUOp_o), .Funct3_o(Funct3_o), .Funct7_o(Funct7_o),
    .OperandA_o(OperandA_o), .OperandB_o(OperandB_o), .ALUResult_i(ALUResult_i),
    .RspValid_o(RspValid_o), .RspReady_i(RspReady_i), .RspId_o(RspId_o),
    .RspData_o(RspData_o), .Busy_o(Busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.op = 2'($urandom_range(0, 3));
    r.f3 = 3'($urandom_range(0, 7));
    r.f7 = 7'($urandom_range(0, 127));
    r.a  = $urandom();
    r.b  = $urandom();
    return r;
  endfunction

  task automatic drive(input logic v0, input req_t p0, input logic v1, input req_t p1);
    Req0Valid_i = v0; Req0ALUOp_i = p0.op; Req0Funct3_i = p0.f3; Req0Funct7_i = p0.f7;
    Req0A_i = p0.a; Req0B_i = p0.b;
    Req1Valid_i = v1; Req1ALUOp_i = p1.op; Req1Funct3_i = p1.f3; Req1Funct7_i = p1.f7;
    Req1A_i = p1.a; Req1B_i = p1.b;
  endtask

  function automatic int pick_winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last_ref == 0) ? 1 : 0;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  // One complete operation: offer, accept, execute, respond after d stall cycles.
  // With hold_r1 set, requester 1 raises a new request while the response waits;
  // it must only see ready in the cycle after the response handshake.
  task automatic do_op(input logic v0, input req_t p0, input logic v1, input req_t p1,
                       input int d, input bit hold_r1);
    int w;
    req_t pw;
    logic [XLEN-1:0] exp;
    @(negedge clk_i);
    drive(v0, p0, v1, p1);
    #1;
    w = pick_winner(v0, v1);
    pw = (w == 1) ? p1 : p0;
    exp = alu_ref(pw.op, pw.f3, pw.f7, pw.a, pw.b);
    chk("idle_busy", 64'(Busy_o), 64'd0);
    chk("idle_rdy0", 64'(Req0Ready_o), 64'(v0 && w == 0));
    chk("idle_rdy1", 64'(Req1Ready_o), 64'(v1 && w == 1));
    @(negedge clk_i);
    last_ref = w;
    Req0Valid_i = 1'b0;
    Req1Valid_i = 1'b0;
    chk("exec_busy",  64'(Busy_o), 64'd1);
    chk("exec_aluop", 64'(ALUOp_o), 64'(pw.op));
    chk("exec_f3",    64'(Funct3_o), 64'(pw.f3));
    chk("exec_f7",    64'(Funct7_o), 64'(pw.f7));
    chk("exec_opa",   64'(OperandA_o), 64'(pw.a));
    chk("exec_opb",   64'(OperandB_o), 64'(pw.b));
    chk("exec_rspv",  64'(RspValid_o), 64'd0);
    @(negedge clk_i);
    chk("resp_valid", 64'(RspValid_o), 64'd1);
    chk("resp_id",    64'(RspId_o), 64'(w));
    chk("resp_data",  64'(RspData_o), 64'(exp));
    if (hold_r1) drive(1'b0, p0, 1'b1, rand_req());
    for (int i = 0; i < d; i++) begin
      @(negedge clk_i);
      chk("stall_valid", 64'(RspValid_o), 64'd1);
      chk("stall_id",    64'(RspId_o), 64'(w));
      chk("stall_data",  64'(RspData_o), 64'(exp));
      chk("stall_busy",  64'(Busy_o), 64'd1);
      chk("stall_rdy1",  64'(Req1Ready_o), 64'd0);
    end
    RspReady_i = 1'b1;
    #1;
    chk("hs_rdy1", 64'(Req1Ready_o), 64'd0);
    @(negedge clk_i);
    RspReady_i = 1'b0;
    chk("post_valid", 64'(RspValid_o), 64'd0);
    chk("post_busy",  64'(Busy_o), 64'd0);
    if (hold_r1) begin
      #1;
      chk("post_rdy1", 64'(Req1Ready_o), 64'd1);
      Req1Valid_i = 1'b0;   // withdraw before the next edge
    end
  endtask

  req_t p0, p1, z;

  initial begin
    z = '{op: 2'b00, f3: 3'd0, f7: 7'd0, a: '0, b: '0};
    #1;
    chk("rst_busy",  64'(Busy_o), 64'd0);
    chk("rst_rspv",  64'(RspValid_o), 64'd0);
    chk("rst_opa",   64'(OperandA_o), 64'd0);
    chk("rst_aluop", 64'(ALUOp_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single R0 add: 5 + 7.
    p0 = '{op: 2'b00, f3: 3'd0, f7: 7'd0, a: 32'd5, b: 32'd7};
    do_op(1'b1, p0, 1'b0, z, 0, 1'b0);

    // R1 subtract: 9 - 9 = 0.
    p1 = '{op: 2'b10, f3: 3'd0, f7: 7'd0, a: 32'd9, b: 32'd9};
    do_op(1'b0, z, 1'b1, p1, 0, 1'b0);

    // Both requesters contending for four operations.
    for (int i = 0; i < 4; i++) do_op(1'b1, rand_req(), 1'b1, rand_req(), 0, 1'b0);

    // Response held off five cycles while R1 waits.
    do_op(1'b1, rand_req(), 1'b0, z, 5, 1'b1);

    // Reset during EXEC discards the operation.
    @(negedge clk_i);
    drive(1'b1, rand_req(), 1'b0, z);
    @(negedge clk_i);
    Req0Valid_i = 1'b0;
    chk("pre_rst_busy", 64'(Busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    chk("async_busy",  64'(Busy_o), 64'd0);
    chk("async_aluop", 64'(ALUOp_o), 64'd0);
    chk("async_opa",   64'(OperandA_o), 64'd0);
    chk("async_opb",   64'(OperandB_o), 64'd0);
    chk("async_id",    64'(RspId_o), 64'd0);
    chk("async_data",  64'(RspData_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    last_ref = 1;
    repeat (2) begin
      @(negedge clk_i);
      chk("no_rsp_after_rst", 64'(RspValid_o), 64'd0);
    end
    do_op(1'b1, rand_req(), 1'b1, rand_req(), 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 30; i++) begin
      int pat;
      pat = $urandom_range(1, 3);
      do_op(logic'(pat[0]), rand_req(), logic'(pat[1]), rand_req(),
            $urandom_range(0, 3), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
